pattern_detector_param: RTL and testbench
=========================================

// Module: pattern_detector_param
// PURPOSE
//  Parametrised successor to the fixed 4-byte PRBS pattern detector. Captures the
//  first PAT_LEN valid symbols after start as a reference pattern, then counts
//  non-overlapping repeats in the stream. Asserts pattern_found once n_pattern
//  occurrences are seen; the captured copy counts as occurrence 1.
//  Sits after the PRBS generator/serialiser on the checker side of the PRBS path.
// PARAMETERS
//  DATA_W   8  symbol width in bits
//  PAT_LEN  4  symbols per pattern (>=1)
//  CNT_W    8  width of n_pattern and match_count
// PORTS
//  CLK            in   1        clock; all logic on rising edge
//  RST            in   1        synchronous, active-high reset
//  start          in   1        pulse: latch n_pattern, begin capture
//  n_pattern      in   CNT_W    required occurrences; sampled only on accepted start
//  in_valid       in   1        in_data qualifier; no beat consumed when low
//  in_data        in   DATA_W   stream symbol
//  busy           out  1        high in CAPTURE or CHECK
//  pattern_found  out  1        high in FOUND; held until start or RST
//  mismatch       out  1        one-cycle pulse per mismatching beat in CHECK
//  match_count    out  CNT_W    occurrences so far, including the captured copy
// BEHAVIOUR
//  Reset: one clock with RST=1 forces state IDLE, idx=0, match_count=0, busy=0,
//   pattern_found=0, mismatch=0 and clears the pattern RAM. RST overrides all
//   inputs in that cycle. Reset mid-operation discards all progress.
//  Outputs are registered. Every response appears the cycle after the causing beat.
//  States: IDLE, CAPTURE, CHECK, FOUND.
//  Accepted start (any state):
//   - latch n_pattern into tgt, set idx=0 and match_count=0, clear pattern_found.
//   - if n_pattern==0, go to FOUND; otherwise go to CAPTURE.
//   - an in_valid beat in the start cycle is ignored.
//   - start in CAPTURE or CHECK aborts and restarts from the beginning.
//  CAPTURE, on in_valid:
//   - pat[idx]=in_data, idx++.
//   - on beat PAT_LEN: idx=0, match_count=1; go to FOUND if tgt==1, else CHECK.
//  CHECK, on in_valid:
//   - in_data==pat[idx]: idx++; at idx==PAT_LEN-1, idx=0 and match_count++.
//     When match_count+1==tgt, go to FOUND.
//   - in_data!=pat[idx]: pulse mismatch. idx=1 if in_data==pat[0], else idx=0
//     (restart check, no KMP overlap). match_count is unchanged.
//  FOUND: pattern_found=1, in_data ignored, match_count frozen (==tgt, or 0 if tgt==0).
//  Width rules:
//   - match_count never exceeds tgt, so no wrap.
//   - idx width is $clog2(PAT_LEN) (min 1); idx wraps only at PAT_LEN.
//   - PAT_LEN==1: every valid beat completes one occurrence.
//  in_valid low in any state: state, idx and match_count hold; mismatch=0.
// TESTING
//  T1 PAT_LEN=4, n=3: start; feed 11 22 33 44 x3 -> match_count 1,2,3; pattern_found=1
//     the cycle after the 12th beat; mismatch never pulses.
//  T2 n=2, pattern 11 22 33 44; feed 11 22 55 11 22 33 44 -> one mismatch pulse at 55;
//     the next 11 restarts at idx=1; FOUND after the final 44.
//  T3 n=0: start -> pattern_found=1 next cycle, busy=0, match_count=0.
//     n=1: FOUND right after the 4th capture beat.
//  T4 in_valid toggling 1/0 through capture and check -> same result as T1;
//     idx and match_count hold during gaps.
//  T5 RST pulse mid-CHECK at match_count=2 -> next cycle all outputs 0 and state IDLE;
//     a new start captures a fresh pattern.
//  T6 start mid-CHECK with n=1 and new data AA BB CC DD -> re-captures and reaches
//     FOUND after DD; the old pattern is not used.

Source files
------------

// File: rtl/pattern_detector_param.sv
// Captures the first PAT_LEN valid symbols after start as a reference pattern, then counts
// non-overlapping repeats until n_pattern occurrences (including the captured copy) are seen.
module pattern_detector_param #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PAT_LEN = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_pattern,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              pattern_found,
  output logic              mismatch,
  output logic [CNT_W-1:0]  match_count
);

  localparam int unsigned IdxW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(PAT_LEN - 1);

  typedef enum logic [1:0] {StIdle, StCapture, StCheck, StFound} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  tgt_q, tgt_d;
  logic              mismatch_q, mismatch_d;
  logic [DATA_W-1:0] pat_q [PAT_LEN];
  logic [DATA_W-1:0] pat_d [PAT_LEN];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      tgt_q      <= '0;
      mismatch_q <= 1'b0;
      for (int unsigned i = 0; i < PAT_LEN; i++) begin
        pat_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      mismatch_q <= mismatch_d;
      pat_q      <= pat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    mismatch_d = 1'b0;
    pat_d      = pat_q;
    if (start) begin
      // A start beat never consumes in_data, even when in_valid is high.
      tgt_d   = n_pattern;
      idx_d   = '0;
      cnt_d   = '0;
      state_d = (n_pattern == '0) ? StFound : StCapture;
    end else if (in_valid) begin
      case (state_q)
        StCapture: begin
          pat_d[idx_q] = in_data;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            cnt_d   = CNT_W'(1);
            state_d = (tgt_q == CNT_W'(1)) ? StFound : StCheck;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
        StCheck: begin
          if (in_data == pat_q[idx_q]) begin
            if (idx_q == LastIdx) begin
              idx_d = '0;
              cnt_d = cnt_q + CNT_W'(1);
              if (cnt_q + CNT_W'(1) == tgt_q) begin
                state_d = StFound;
              end
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end else begin
            // Restart without overlap search; a symbol equal to pat[0] opens a new attempt.
            mismatch_d = 1'b1;
            idx_d      = (PAT_LEN > 1 && in_data == pat_q[0]) ? IdxW'(1) : '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy          = (state_q == StCapture) || (state_q == StCheck);
    pattern_found = (state_q == StFound);
    mismatch      = mismatch_q;
    match_count   = cnt_q;
  end

endmodule

// File: tb/tb_pattern_detector_param.sv
// Directed and randomized bench for pattern_detector_param against a queue-based model.
module tb_pattern_detector_param;

  localparam int PL = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic [7:0] n_pattern;
  logic       in_valid;
  logic [7:0] in_data;
  logic       busy;
  logic       pattern_found;
  logic       mismatch;
  logic [7:0] match_count;

  int n_checks = 0;
  int n_fail   = 0;

  pattern_detector_param #(
    .DATA_W (8),
    .PAT_LEN(PL),
    .CNT_W  (8)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .n_pattern    (n_pattern),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .busy         (busy),
    .pattern_found(pattern_found),
    .mismatch     (mismatch),
    .match_count  (match_count)
  );

  always #5 CLK = ~CLK;

  // Model: a run is active after start; the captured pattern is the queue, capture ends when
  // the queue is full, and done means the required number of occurrences has been reached.
  logic [7:0] m_pat[$];
  int         m_pos    = 0;
  int         m_count  = 0;
  int         m_tgt    = 0;
  bit         m_active = 1'b0;
  bit         m_done   = 1'b0;
  bit         m_mm     = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    m_mm = 1'b0;
    if (RST) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_pat.delete();
      m_pos    = 0;
      m_count  = 0;
      m_tgt    = 0;
    end else if (start) begin
      m_active = 1'b1;
      m_tgt    = int'(n_pattern);
      m_pat.delete();
      m_pos    = 0;
      m_count  = 0;
      m_done   = (n_pattern == 8'd0);
    end else if (in_valid && m_active && !m_done) begin
      if (m_pat.size() < PL) begin
        m_pat.push_back(in_data);
        if (m_pat.size() == PL) begin
          m_count = 1;
          if (m_tgt == 1) m_done = 1'b1;
        end
      end else if (in_data == m_pat[m_pos]) begin
        m_pos++;
        if (m_pos == PL) begin
          m_pos = 0;
          m_count++;
          if (m_count == m_tgt) m_done = 1'b1;
        end
      end else begin
        m_mm  = 1'b1;
        m_pos = (in_data == m_pat[0]) ? 1 : 0;
      end
    end
  endtask

  // Model advances on each rising edge; DUT outputs are compared on the falling edge.
  initial begin
    forever begin
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      chk("busy", 32'(busy), 32'(m_active && !m_done));
      chk("pattern_found", 32'(pattern_found), 32'(m_done));
      chk("mismatch", 32'(mismatch), 32'(m_mm));
      chk("match_count", 32'(match_count), 32'(m_count));
    end
  end

  task automatic cyc(input logic s, input logic [7:0] n, input logic v, input logic [7:0] d);
    start     = s;
    n_pattern = n;
    in_valid  = v;
    in_data   = d;
    @(negedge CLK);
  endtask

  logic [7:0] p1 [PL] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] p2 [PL] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [7:0] sp [PL];

  initial begin
    int k;
    RST = 1'b1;
    cyc(1'b0, 8'd0, 1'b0, 8'h00);
    RST = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_found", 32'(pattern_found), 32'd0);
    chk("reset_count", 32'(match_count), 32'd0);

    // T1: three back-to-back occurrences
    cyc(1'b1, 8'd3, 1'b1, 8'h11);
    chk("t1_busy_after_start", 32'(busy), 32'd1);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < PL; i++) cyc(1'b0, 8'd0, 1'b1, p1[i]);
      chk("t1_count", 32'(match_count), 32'(r + 1));
    end
    chk("t1_found", 32'(pattern_found), 32'd1);
    chk("t1_model_count", 32'(m_count), 32'd3);

    // T2: one mismatch, then recovery
    cyc(1'b1, 8'd2, 1'b0, 8'h00);
    for (int i = 0; i < PL; i++) cyc(1'b0, 8'd0, 1'b1, p1[i]);
    cyc(1'b0, 8'd0, 1'b1, 8'h11);
    cyc(1'b0, 8'd0, 1'b1, 8'h22);
    cyc(1'b0, 8'd0, 1'b1, 8'h55);
    chk("t2_mismatch_pulse", 32'(mismatch), 32'd1);
    cyc(1'b0, 8'd0, 1'b1, 8'h11);
    chk("t2_mismatch_clear", 32'(mismatch), 32'd0);
    cyc(1'b0, 8'd0, 1'b1, 8'h22);
    cyc(1'b0, 8'd0, 1'b1, 8'h33);
    chk("t2_not_yet_found", 32'(pattern_found), 32'd0);
    cyc(1'b0, 8'd0, 1'b1, 8'h44);
    chk("t2_found", 32'(pattern_found), 32'd1);
    chk("t2_count", 32'(match_count), 32'd2);

    // T3: n=0 and n=1
    cyc(1'b1, 8'd0, 1'b0, 8'h00);
    chk("t3_n0_found", 32'(pattern_found), 32'd1);
    chk("t3_n0_busy", 32'(busy), 32'd0);
    chk("t3_n0_count", 32'(match_count), 32'd0);
    cyc(1'b1, 8'd1, 1'b0, 8'h00);
    for (int i = 0; i < PL - 1; i++) cyc(1'b0, 8'd0, 1'b1, p2[i]);
    chk("t3_n1_pending", 32'(pattern_found), 32'd0);
    cyc(1'b0, 8'd0, 1'b1, p2[PL-1]);
    chk("t3_n1_found", 32'(pattern_found), 32'd1);
    chk("t3_n1_count", 32'(match_count), 32'd1);

    // T4: gaps between every beat
    cyc(1'b1, 8'd3, 1'b0, 8'h00);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < PL; i++) begin
        cyc(1'b0, 8'd0, 1'b1, p1[i]);
        cyc(1'b0, 8'd0, 1'b0, 8'hEE);
      end
      chk("t4_count_hold", 32'(match_count), 32'(r + 1));
    end
    chk("t4_found", 32'(pattern_found), 32'd1);

    // T5: reset mid-check, then fresh capture
    cyc(1'b1, 8'd4, 1'b0, 8'h00);
    for (int i = 0; i < 2 * PL; i++) cyc(1'b0, 8'd0, 1'b1, p1[i % PL]);
    chk("t5_count_before", 32'(match_count), 32'd2);
    RST = 1'b1;
    cyc(1'b1, 8'd1, 1'b1, 8'h11);
    RST = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_found", 32'(pattern_found), 32'd0);
    chk("t5_count", 32'(match_count), 32'd0);
    cyc(1'b1, 8'd2, 1'b0, 8'h00);
    for (int i = 0; i < PL; i++) cyc(1'b0, 8'd0, 1'b1, p2[i]);
    for (int i = 0; i < PL; i++) cyc(1'b0, 8'd0, 1'b1, p2[i]);
    chk("t5_new_found", 32'(pattern_found), 32'd1);

    // T6: restart mid-check with a new pattern
    cyc(1'b1, 8'd3, 1'b0, 8'h00);
    for (int i = 0; i < PL + 2; i++) cyc(1'b0, 8'd0, 1'b1, p1[i % PL]);
    cyc(1'b1, 8'd1, 1'b0, 8'h00);
    for (int i = 0; i < PL - 1; i++) cyc(1'b0, 8'd0, 1'b1, p2[i]);
    chk("t6_pending", 32'(pattern_found), 32'd0);
    cyc(1'b0, 8'd0, 1'b1, p2[PL-1]);
    chk("t6_found", 32'(pattern_found), 32'd1);
    chk("t6_count", 32'(match_count), 32'd1);

    // Randomized traffic biased towards repeating the current pattern
    for (int i = 0; i < PL; i++) sp[i] = 8'($urandom);
    k = 0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      logic s, v;
      logic [7:0] n, d;
      r   = $urandom_range(0, 99);
      RST = (r < 1);
      s   = (r >= 1 && r < 4);
      n   = 8'($urandom_range(0, 4));
      if (s) begin
        for (int i = 0; i < PL; i++) sp[i] = 8'($urandom_range(0, 7));
        k = 0;
      end
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 8) begin
        d = sp[k];
        if (v) k = (k + 1) % PL;
      end else begin
        d = 8'($urandom_range(0, 7));
      end
      cyc(s, n, v, d);
    end
    RST = 1'b0;
    cyc(1'b0, 8'd0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
